// File: rtl/pipelined_bls_addsub.sv
// WIDTH-bit add/subtract unit pipelined as one GROUP-bit lookahead slice per stage,
// with the borrow/carry registered between slices and a deskewed output register.
module pipelined_bls_addsub #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int STAGES = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0) begin : g_bad_width
    $error("pipelined_bls_addsub: WIDTH must be a multiple of GROUP");
  end

  // Handshake: a beat transfers on a cycle where valid & ready are both high at the
  // rising edge. ready never depends on valid of the same side; the whole pipeline
  // moves together (adv) or holds together, so nothing is dropped or duplicated.
  logic adv;

  // Per-stage registers: operand skew copies, partial result (lower slices already
  // filled in), borrow/carry out of the slice, mode and valid.
  logic [WIDTH-1:0] x_q [STAGES];
  logic [WIDTH-1:0] y_q [STAGES];
  logic [WIDTH-1:0] r_q [STAGES];
  logic             c_q [STAGES];
  logic             m_q [STAGES];
  logic             v_q [STAGES];

  logic [WIDTH-1:0] x_d [STAGES];
  logic [WIDTH-1:0] y_d [STAGES];
  logic [WIDTH-1:0] r_d [STAGES];
  logic             c_d [STAGES];
  logic             m_d [STAGES];
  logic             v_d [STAGES];
  logic [GROUP:0]   sc  [STAGES];

  logic             out_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;
  logic             ovf_d;

  // Flattened lookahead: every carry is a sum of generate terms gated by the
  // propagates above them, so no carry depends on another computed carry.
  function automatic logic [GROUP:0] slice_f(
    input logic [GROUP-1:0] a,
    input logic [GROUP-1:0] b,
    input logic             cin,
    input logic             add
  );
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] h;
    logic [GROUP-1:0] s;
    logic [GROUP:0]   c;
    logic             t;
    h = a ^ b;
    g = add ? (a & b) : (~a & b);
    p = add ? h : ~h;
    c = '0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      t = cin;
      for (int j = 0; j <= i; j++) t = t & p[j];
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        c[i+1] = c[i+1] | t;
      end
    end
    s = h ^ c[GROUP-1:0];
    return {c[GROUP], s};
  endfunction

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      x_d[k] = '0;
      y_d[k] = '0;
      r_d[k] = '0;
      c_d[k] = 1'b0;
      m_d[k] = 1'b0;
      v_d[k] = 1'b0;
      sc[k]  = '0;
    end
    x_d[0] = X;
    y_d[0] = Y;
    m_d[0] = mode;
    v_d[0] = in_valid;
    sc[0]  = slice_f(X[GROUP-1:0], Y[GROUP-1:0], Bin, mode);
    r_d[0][GROUP-1:0] = sc[0][GROUP-1:0];
    c_d[0] = sc[0][GROUP];
    for (int k = 1; k < STAGES; k++) begin
      x_d[k] = x_q[k-1];
      y_d[k] = y_q[k-1];
      m_d[k] = m_q[k-1];
      v_d[k] = v_q[k-1];
      sc[k]  = slice_f(x_q[k-1][k*GROUP +: GROUP], y_q[k-1][k*GROUP +: GROUP],
                       c_q[k-1], m_q[k-1]);
      r_d[k] = r_q[k-1];
      r_d[k][k*GROUP +: GROUP] = sc[k][GROUP-1:0];
      c_d[k] = sc[k][GROUP];
    end
  end

  // Signed overflow from the operand sign bits carried alongside the result.
  always_comb begin
    ovf_d = 1'b0;
    if (m_q[STAGES-1]) begin
      ovf_d = (x_q[STAGES-1][WIDTH-1] == y_q[STAGES-1][WIDTH-1]) &&
              (r_q[STAGES-1][WIDTH-1] != x_q[STAGES-1][WIDTH-1]);
    end else begin
      ovf_d = (x_q[STAGES-1][WIDTH-1] != y_q[STAGES-1][WIDTH-1]) &&
              (r_q[STAGES-1][WIDTH-1] != x_q[STAGES-1][WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        r_q[k] <= '0;
        c_q[k] <= 1'b0;
        m_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
        r_q[k] <= r_d[k];
        c_q[k] <= c_d[k];
        m_q[k] <= m_d[k];
        v_q[k] <= v_d[k];
      end
      out_valid_q <= v_q[STAGES-1];
      diff_q      <= r_q[STAGES-1];
      bout_q      <= c_q[STAGES-1];
      ovf_q       <= ovf_d;
    end
  end

  // Flags are gated by out_valid so an idle or reset unit reads all-zero.
  assign out_valid = out_valid_q;
  assign Diff      = out_valid_q ? diff_q : '0;
  assign Bout      = out_valid_q & bout_q;
  assign Ovf       = out_valid_q & ovf_q;
  assign Zero      = out_valid_q & (diff_q == '0);

endmodule

// File: doc/pipelined_bls_addsub.md
Name: pipelined_bls_addsub

Overview:
- Parametrised successor to the 4-bit borrow-lookahead subtractor: a WIDTH-bit add/subtract unit built from GROUP-bit lookahead slices, one slice per pipeline stage.
- The borrow/carry is registered between stages. Throughput is one operation per cycle. Latency is WIDTH/GROUP cycles.
- Adds an add/subtract mode select, signed-overflow and zero flags, and a valid/ready handshake with whole-pipeline stall.
- Sits in the datapath labs as the shared arithmetic unit for later ALU work.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be a multiple of GROUP; otherwise elaboration fails with $error.
- GROUP, 4: bits per lookahead slice, equal to bits per pipeline stage.
- STAGES: derived as WIDTH/GROUP, not overridable. Equals the latency in cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit accepts a beat this cycle
- mode  input  1  0 = subtract, 1 = add
- X  input  WIDTH  minuend / addend A
- Y  input  WIDTH  subtrahend / addend B
- Bin  input  1  borrow-in (subtract) or carry-in (add)
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- Diff  output  WIDTH  result
- Bout  output  1  borrow-out (subtract) or carry-out (add)
- Ovf  output  1  two's-complement signed overflow
- Zero  output  1  Diff == 0

Behaviour:
- Reset (rst=1 at posedge):
  - All stage valid bits clear, so out_valid=0.
  - Diff, Bout, Ovf and Zero read 0.
  - Data registers are also cleared.
  - Reset overrides any in-flight operation; those results are discarded and never emitted.
  - in_ready=1 in the cycle after reset deasserts.
- Advance: adv = !out_valid | out_ready. in_ready = adv, combinational.
  - When adv=1, every stage shifts one position.
  - When adv=0, all stages hold: no bubble collapse, no data loss.
- Accept: a beat is taken when in_valid & in_ready. If in_valid=0 while adv=1, a bubble enters (valid=0).
- Stage k (0..STAGES-1):
  - Processes bits [k*GROUP +: GROUP] using the operand bits carried down the skew registers.
  - Uses the borrow/carry registered from stage k-1. Stage 0 uses Bin.
  - Stage k registers its GROUP result bits, its borrow/carry out, and mode.
- Slice arithmetic (lookahead within a slice, no ripple):
  - Subtract: g_i = ~x_i & y_i, p_i = ~(x_i ^ y_i), b_{i+1} = g_i | p_i & b_i, d_i = x_i ^ y_i ^ b_i.
  - Add: g_i = x_i & y_i, p_i = x_i ^ y_i, c_{i+1} = g_i | p_i & c_i, s_i = p_i ^ c_i.
- Output deskew: lower result slices are delayed so all WIDTH bits of one operation appear together on Diff.
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+STAGES, assuming no stall. Stalls add cycle-for-cycle.
- Result semantics:
  - Subtract: Diff = (X - Y - Bin) mod 2^WIDTH; Bout = 1 iff X < Y + Bin (unsigned).
  - Add: Diff = (X + Y + Bin) mod 2^WIDTH; Bout = unsigned carry-out.
- Ovf:
  - Subtract: X[MSB] != Y[MSB] and Diff[MSB] != X[MSB].
  - Add: X[MSB] == Y[MSB] and Diff[MSB] != X[MSB].
- Zero: Diff == 0, computed from the deskewed output register.
- Hold: while out_valid & !out_ready, Diff, Bout, Ovf, Zero and out_valid stay stable.
- Mode may change every beat. It travels with its operation; mixed add/sub in flight is legal.

Test Plan (WIDTH=16, GROUP=4, latency 4):
- Sub with cross-slice borrow: X=0x1000, Y=0x0001, Bin=0 -> after 4 cycles Diff=0x0FFF, Bout=0, Ovf=0, Zero=0. The borrow ripples through stages 0-2.
- Sub with borrow-in underflow: X=0x0000, Y=0xFFFF, Bin=1 -> Diff=0x0000, Bout=1, Ovf=0, Zero=1.
- Signed overflow, both modes: add X=0x7FFF, Y=0x0001 -> Diff=0x8000, Bout=0, Ovf=1. Sub X=0x8000, Y=0x0001 -> Diff=0x7FFF, Bout=0, Ovf=1.
- Streaming with mixed modes: 4 back-to-back beats (sub 0x1234-0x0234, add 0xFFFF+0x0001, sub 0x0005-0x0005 with Bin=1, add 0x00FF+0x0F01) -> on 4 consecutive cycles:
  - 0x1000 / Bout=0
  - 0x0000 / Bout=1, Zero=1
  - 0xFFFF / Bout=1
  - 0x1000 / Bout=0
- Backpressure: hold out_ready=0 for 3 cycles while the result of beat 1 is valid -> in_ready=0 and outputs frozen. After release, all 4 results emerge in order with none lost or duplicated.
- Reset mid-flight: assert rst for 1 cycle with 3 ops in flight -> out_valid stays 0 with no stale results. A new beat issued after reset emerges 4 cycles later, correct.
